player_projectile_ctrl: RTL and testbench

//  Player bullet controller; sits directly upstream of the invader collision stage.

---
 rtl/player_projectile_ctrl.sv | 151 +++++++++++++++
 tb/tb_player_projectile_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/player_projectile_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : player_projectile_ctrl
// Brief   : Player bullet controller. Spawns a single bullet on a fire edge,
//           advances it upward once per frame tick, retires it on a hit from
//           the collision stage or when it leaves the top of the screen, then
//           holds a fire cooldown for COOLDOWN_FRAMES frame ticks.
// Ports   : clk, rst (async, active-high)
//           frame_tick      - one-cycle pulse per video frame
//           fire            - synchronised fire button level, rising edge fires
//           player_xpos     - ship left x, sampled only when a shot is fired
//           bullet_hit      - registered hit pulse from the collision stage
//           projectile_xpos - bullet left x
//           projectile_ypos - bullet top y
//           bullet_active   - high while the bullet is in flight
//           shot_fired      - one-cycle pulse when a bullet is spawned
// Revision: 1.0 - initial release
// ============================================================================
module player_projectile_ctrl #(
   parameter int SPEED            = 8,
   parameter int SPAWN_Y          = 700,
   parameter int TOP_Y            = 0,
   parameter int PLAYER_WIDTH     = 64,
   parameter int PROJECTILE_WIDTH = 16,
   parameter int COOLDOWN_FRAMES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        fire,
   input  logic [11:0] player_xpos,
   input  logic        bullet_hit,
   output logic [11:0] projectile_xpos,
   output logic [11:0] projectile_ypos,
   output logic        bullet_active,
   output logic        shot_fired
);

   localparam int                 c_CNT_W    = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [12:0]        c_X_OFFSET = 13'((PLAYER_WIDTH - PROJECTILE_WIDTH) / 2);
   localparam logic [12:0]        c_STEP_MIN = 13'(TOP_Y + SPEED);
   localparam logic [11:0]        c_SPEED    = 12'(SPEED);
   localparam logic [11:0]        c_SPAWN_Y  = 12'(SPAWN_Y);
   localparam logic [c_CNT_W-1:0] c_CD_LAST  = c_CNT_W'(COOLDOWN_FRAMES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLYING   = 2'd1,
      S_COOLDOWN = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_fire_d;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [11:0]          r_xpos;
   logic [11:0]          r_ypos;
   logic                 r_shot;

   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic [11:0]          w_xpos_nxt;
   logic [11:0]          w_ypos_nxt;
   logic                 w_shot_nxt;
   logic                 w_fire_edge;
   logic [12:0]          w_spawn_sum;
   logic [11:0]          w_spawn_x;

   assign w_fire_edge = fire & ~r_fire_d;

   // Centre the bullet on the ship; carry out of 12 bits clamps to the right edge.
   assign w_spawn_sum = {1'b0, player_xpos} + c_X_OFFSET;
   assign w_spawn_x   = w_spawn_sum[12] ? 12'hFFF : w_spawn_sum[11:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_fire_d <= 1'b0;
         r_cnt    <= '0;
         r_xpos   <= '0;
         r_ypos   <= '0;
         r_shot   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_fire_d <= fire;
         r_cnt    <= w_cnt_nxt;
         r_xpos   <= w_xpos_nxt;
         r_ypos   <= w_ypos_nxt;
         r_shot   <= w_shot_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_xpos_nxt  = r_xpos;
      w_ypos_nxt  = r_ypos;
      w_shot_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_fire_edge) begin
               w_state_nxt = S_FLYING;
               w_xpos_nxt  = w_spawn_x;
               w_ypos_nxt  = c_SPAWN_Y;
               w_shot_nxt  = 1'b1;
            end
         end

         S_FLYING: begin
            // A hit retires the bullet even if a frame tick arrives with it,
            // so the reported y is the one the collision stage matched against.
            if (bullet_hit) begin
               w_state_nxt = S_COOLDOWN;
               w_cnt_nxt   = '0;
            end else if (frame_tick) begin
               if ({1'b0, r_ypos} >= c_STEP_MIN) begin
                  w_ypos_nxt = r_ypos - c_SPEED;
               end else begin
                  // Another step would cross the top bound: retire instead of wrapping.
                  w_state_nxt = S_COOLDOWN;
                  w_cnt_nxt   = '0;
               end
            end
         end

         S_COOLDOWN: begin
            if (frame_tick) begin
               if (r_cnt == c_CD_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + c_CNT_ONE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign projectile_xpos = r_xpos;
   assign projectile_ypos = r_ypos;
   assign bullet_active   = (r_state == S_FLYING);
   assign shot_fired      = r_shot;

endmodule
`default_nettype wire

// File: tb/tb_player_projectile_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_projectile_ctrl
// Brief   : Directed testbench for player_projectile_ctrl with hand-computed
//           expected values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_player_projectile_ctrl;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        fire;
   logic [11:0] player_xpos;
   logic        bullet_hit;
   logic [11:0] projectile_xpos;
   logic [11:0] projectile_ypos;
   logic        bullet_active;
   logic        shot_fired;

   int n_checks;
   int n_errors;

   player_projectile_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .frame_tick      (frame_tick),
      .fire            (fire),
      .player_xpos     (player_xpos),
      .bullet_hit      (bullet_hit),
      .projectile_xpos (projectile_xpos),
      .projectile_ypos (projectile_ypos),
      .bullet_active   (bullet_active),
      .shot_fired      (shot_fired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      frame_tick  = 1'b0;
      fire        = 1'b0;
      player_xpos = 12'd0;
      bullet_hit  = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_active", 32'(bullet_active), 32'd0);
      check("rst_shot",   32'(shot_fired),    32'd0);
      check("rst_x",      32'(projectile_xpos), 32'd0);
      check("rst_y",      32'(projectile_ypos), 32'd0);
      rst = 1'b0;
      step();

      // Spawn at x=300 -> 300 + 24 = 324, y = 700
      player_xpos = 12'd300;
      fire = 1'b1;
      step();
      check("spawn_active", 32'(bullet_active), 32'd1);
      check("spawn_shot",   32'(shot_fired),    32'd1);
      check("spawn_x",      32'(projectile_xpos), 32'd324);
      check("spawn_y",      32'(projectile_ypos), 32'd700);
      step();
      check("shot_one_cycle", 32'(shot_fired),    32'd0);
      check("held_active",    32'(bullet_active), 32'd1);
      repeat (3) tick();
      check("y_after_3", 32'(projectile_ypos), 32'd676);

      // Off-screen miss: 87 ticks total -> y=4, 88th retires
      fire = 1'b0;
      repeat (84) tick();
      check("y_after_87",      32'(projectile_ypos), 32'd4);
      check("active_after_87", 32'(bullet_active),   32'd1);
      tick();
      check("miss_active", 32'(bullet_active),   32'd0);
      check("miss_y_hold", 32'(projectile_ypos), 32'd4);
      check("miss_x_hold", 32'(projectile_xpos), 32'd324);

      // Edge during cooldown is dropped
      repeat (9) tick();
      fire = 1'b1;
      step();
      check("cd_edge_active", 32'(bullet_active), 32'd0);
      check("cd_edge_shot",   32'(shot_fired),    32'd0);
      tick();               // 10th cooldown tick -> IDLE, fire still held
      step();
      step();
      check("held_no_repeat", 32'(bullet_active), 32'd0);
      fire = 1'b0;
      step();
      fire = 1'b1;
      step();
      check("refire_active", 32'(bullet_active), 32'd1);
      check("refire_shot",   32'(shot_fired),    32'd1);

      // Fly to y=500, re-press mid-flight, then hit with same-cycle tick
      fire = 1'b0;
      repeat (25) tick();
      check("y_500", 32'(projectile_ypos), 32'd500);
      fire = 1'b1;
      step();
      check("fly_repress_shot", 32'(shot_fired),    32'd0);
      check("fly_repress_y",    32'(projectile_ypos), 32'd500);
      frame_tick = 1'b1;
      bullet_hit = 1'b1;
      step();
      frame_tick = 1'b0;
      bullet_hit = 1'b0;
      check("hit_active", 32'(bullet_active),   32'd0);
      check("hit_y_hold", 32'(projectile_ypos), 32'd500);
      bullet_hit = 1'b1;
      step();
      bullet_hit = 1'b0;
      check("cd_stray_hit_active", 32'(bullet_active),   32'd0);
      check("cd_stray_hit_y",      32'(projectile_ypos), 32'd500);

      // Back to IDLE, stray hit there
      fire = 1'b0;
      repeat (10) tick();
      bullet_hit = 1'b1;
      step();
      bullet_hit = 1'b0;
      check("idle_stray_hit", 32'(bullet_active), 32'd0);

      // Spawn x saturation: 4090 + 24 clamps to 4095
      player_xpos = 12'd4090;
      fire = 1'b1;
      step();
      check("sat_x",      32'(projectile_xpos), 32'd4095);
      check("sat_active", 32'(bullet_active),   32'd1);
      check("sat_y",      32'(projectile_ypos), 32'd700);
      fire = 1'b0;
      step();
      tick();
      check("sat_y_step", 32'(projectile_ypos), 32'd692);

      // Asynchronous reset mid-flight, observed before the next clock edge
      #3 rst = 1'b1;
      #1;
      check("async_active", 32'(bullet_active),   32'd0);
      check("async_x",      32'(projectile_xpos), 32'd0);
      check("async_y",      32'(projectile_ypos), 32'd0);
      check("async_shot",   32'(shot_fired),      32'd0);
      #2 rst = 1'b0;
      step();
      check("post_rst_idle", 32'(bullet_active), 32'd0);
      fire = 1'b1;
      step();
      check("post_rst_fire_active", 32'(bullet_active),   32'd1);
      check("post_rst_fire_x",      32'(projectile_xpos), 32'd4095);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
